// File: rtl/ixc_gather_pkg.sv
// Shared sizing and types for the 296-bit assign-bus beat reassembler.
// Beat count and last-beat width are derived from WIDTH and BEAT.
package ixc_gather_pkg;

    localparam int WIDTH     = 296;
    localparam int BEAT      = 32;
    localparam int BEATS     = (WIDTH + BEAT - 1) / BEAT;
    localparam int LAST_BITS = WIDTH - (BEATS - 1) * BEAT;

    typedef logic [3:0]       beat_idx_t;
    typedef logic [WIDTH-1:0] word_t;

    localparam beat_idx_t LAST_IDX = beat_idx_t'(BEATS - 1);

endpackage

// File: rtl/ixc_bus_gather_296.sv
// Reassembles 32-bit LSB-first beats into one 296-bit word behind a valid/ready port.
// The assembly register is separate from the output register so beats 0..8 never stall.
module ixc_bus_gather_296
    import ixc_gather_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BEAT-1:0] in_data,
    input  logic            in_first,
    output logic            out_valid,
    input  logic            out_ready,
    output word_t           out_data,
    output logic            err_resync
);

    beat_idx_t beat_cnt;
    word_t     asm_word;
    word_t     asm_next;
    beat_idx_t wr_idx;
    logic      accept;
    logic      resync;
    logic      last;

    // The final beat is the only one that can collide with an unconsumed word.
    assign in_ready = !((beat_cnt == LAST_IDX) && out_valid && !out_ready);
    assign accept   = in_valid && in_ready;
    assign resync   = accept && in_first && (beat_cnt != '0);
    assign wr_idx   = resync ? '0 : beat_cnt;
    assign last     = accept && (wr_idx == LAST_IDX);

    // Stage 0: merge the accepted beat into the assembly word
    always_comb begin
        asm_next = asm_word;
        if (accept) begin
            if (wr_idx == LAST_IDX) begin
                asm_next[WIDTH-1 -: LAST_BITS] = in_data[LAST_BITS-1:0];
            end else begin
                for (int k = 0; k < BEATS - 1; k++) begin
                    if (wr_idx == beat_idx_t'(k)) begin
                        asm_next[k*BEAT +: BEAT] = in_data;
                    end
                end
            end
        end
    end

    // Stage 1: counter, assembly register and output holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt   <= '0;
            asm_word   <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            err_resync <= 1'b0;
        end else begin
            err_resync <= resync;
            if (accept) begin
                asm_word <= asm_next;
                beat_cnt <= last ? '0 : wr_idx + 1'b1;
            end
            // A load in the drain cycle keeps out_valid high with the new word.
            if (last) begin
                out_data  <= asm_next;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
